rom_lut_sequencer: RTL and testbench
====================================

# rom_lut_sequencer

Controller that shares one synchronous ROM lookup table between NUM_REQ requesters. Each request is a burst: start address plus beat count. The sequencer arbitrates round-robin, drives the ROM address port one beat per cycle with address wrap-around, and returns tagged read data. It sits between the USB-3W command logic and the single ROM instance, which has a 1-cycle registered read and no enable.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ROM_ADDR_WIDTH, 8, ROM address width
- ROM_DATA_WIDTH, 8, ROM data width
- LEN_WIDTH, 4, burst length field width; field value = beats − 1
- ID_WIDTH, 3, requester index width; must satisfy 2**ID_WIDTH ≥ NUM_REQ
- in_clk  in  1  single clock, all logic on rising edge
- in_rst_n  in  1  asynchronous, active-low reset
- in_req_valid  in  NUM_REQ  per-requester request valid
- in_req_addr  in  NUM_REQ*ROM_ADDR_WIDTH  start address, requester i at slice i
- in_req_len  in  NUM_REQ*LEN_WIDTH  beats − 1, requester i at slice i
- out_req_ready  out  NUM_REQ  one-hot accept strobe, combinational
- out_rom_addr  out  ROM_ADDR_WIDTH  to ROM in_addr, combinational
- in_rom_data  in  ROM_DATA_WIDTH  from ROM out_data
- out_rsp_valid  out  1  response beat valid, registered
- out_rsp_id  out  ID_WIDTH  requester index of the beat
- out_rsp_last  out  1  final beat of the burst
- out_rsp_data  out  ROM_DATA_WIDTH  ROM word

## Operation
- States: IDLE and BURST.
- IDLE:
  - If any in_req_valid is set, grant the first valid index at or after rr_ptr, searching cyclically.
  - Assert out_req_ready[g] for that cycle only. The request is accepted on that edge.
  - out_rom_addr = in_req_addr[g]. This is beat 0.
  - If len = 0: stay in IDLE; the beat is last.
  - Else: go to BURST with cur_addr = addr + 1 and remaining = len − 1.
  - rr_ptr ← (g + 1) mod NUM_REQ on every grant.
- BURST:
  - No out_req_ready is asserted; the grant is held.
  - out_rom_addr = cur_addr.
  - Each cycle, cur_addr increments modulo 2**ROM_ADDR_WIDTH, so 0xFF is followed by 0x00.
  - When remaining = 0, that beat is last and the next state is IDLE. Otherwise remaining decrements.
- When no grant is active, out_rom_addr holds its last value. It must not cause spurious responses.
- A requester must hold valid, addr and len stable until its ready strobe. Valid dropped before ready is allowed; that request is simply not taken.
- Responses have no backpressure. Consumers sink every beat.
- Out-of-range requester indices do not exist. NUM_REQ outside 2..8 is a lint/elaboration error.

## Timing
- Throughput is 1 beat per cycle, including back-to-back bursts. The IDLE grant cycle issues beat 0, so there are no bubbles between bursts.
- Latency, address to response:
  - Beat address is driven in cycle t and sampled by the ROM at edge t.
  - in_rom_data is valid in t+1, and the response register captures it at edge t+1.
  - out_rsp_* is visible in cycle t+2, i.e. 2 cycles.
- Tag pipeline: {valid, id, last} travels one register stage alongside the ROM read, then joins the data in the response register.
- Simultaneous requests are resolved only by rr_ptr. The fixed-index case with rr_ptr = 0 favours index 0.
- A request arriving mid-burst waits. It is granted in the IDLE cycle after the last beat, in rr order.
- Reset values, applied asynchronously:
  - state = IDLE, rr_ptr = 0, tag pipeline valid = 0, cur_addr = 0, remaining = 0.
  - out_rsp_valid = 0, out_rsp_id = 0, out_rsp_last = 0, out_rsp_data = 0.
  - out_req_ready = 0 while in_rst_n is low.
- Reset mid-burst: the burst is abandoned and in-flight beats are discarded. No response is produced after reset deassertion until a new grant.

## Structure
- Shared header rom_lut_defs.vh holds:
  - State encodings ST_IDLE and ST_BURST.
  - Default widths for ROM_ADDR_WIDTH, ROM_DATA_WIDTH and LEN_WIDTH, shared with the ROM instance.
- One sub-module, rr_arbiter: NUM_REQ-wide cyclic priority pick from a request vector and rr_ptr. It outputs a one-hot grant and the encoded index, and is purely combinational.
- The ROM is instantiated by the parent, not inside this block.

## Test plan
All scenarios use a ROM image of mem[a] = a XOR 8'hA5, with 8-bit address and data.
- Single beat: req0 addr 0x10, len 0. Expect ready0 for 1 cycle, then 2 cycles later one response {id 0, last 1, data 0xB5}.
- Burst with wrap: req1 addr 0xFE, len 3. Expect 4 consecutive beats with data 0x5B, 0x5A, 0xA5, 0xA4 (addresses 0xFE, 0xFF, 0x00, 0x01). last is set on the 4th beat only, and all beats carry id 1.
- Round-robin: req0 and req1 continuously valid, both with len 0. Expect grants alternating 0,1,0,1 with no idle cycles and responses in the same order.
- Arrival mid-burst: req0 len 7 active, req1 asserted at beat 2. Expect ready1 in the cycle right after req0's 8th beat, with no gap between the two response streams.
- Reset mid-burst: req0 len 15 in progress, pulse in_rst_n low for 1 cycle after beat 5 is issued. Expect all outputs immediately 0 and no response beats until a new request is granted. rr_ptr = 0 afterwards, so with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/rom_lut_sequencer_pkg.sv
// Shared definitions for the ROM lookup-table sequencer.
// Holds the controller state encoding and the default ROM/burst widths,
// which the parent also uses when it sizes the single ROM instance.
package rom_lut_sequencer_pkg;

    localparam int DEF_ROM_ADDR_WIDTH = 8;
    localparam int DEF_ROM_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH      = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } seq_state_e;

endpackage

// File: rtl/rom_lut_sequencer_rr_arbiter.sv
// rr_arbiter: combinational cyclic-priority pick.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index with highest priority this cycle
//   gnt  - one-hot grant (all zero when nothing requests)
//   idx  - encoded index of the granted requester
//   any  - at least one request present
module rr_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 3
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any
);

    int c;

    // Scan NUM_REQ slots starting at ptr; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = ID_WIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/rom_lut_sequencer.sv
// rom_lut_sequencer: shares one synchronous ROM (1-cycle registered read,
// no enable) between NUM_REQ burst requesters.
// Ports:
//   in_clk, in_rst_n       - clock, async active-low reset
//   in_req_valid/addr/len  - per-requester burst request (len = beats-1),
//                            requester i in slice i
//   out_req_ready          - one-hot accept strobe (combinational)
//   out_rom_addr           - ROM address (combinational)
//   in_rom_data            - ROM read data, one cycle after the address
//   out_rsp_valid/id/last/data - registered tagged response beat
module rom_lut_sequencer
    import rom_lut_sequencer_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ROM_ADDR_WIDTH = DEF_ROM_ADDR_WIDTH,
    parameter int ROM_DATA_WIDTH = DEF_ROM_DATA_WIDTH,
    parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int ID_WIDTH       = 3
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic [NUM_REQ-1:0]            in_req_valid,
    input  logic [NUM_REQ*ROM_ADDR_WIDTH-1:0] in_req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  in_req_len,
    output logic [NUM_REQ-1:0]            out_req_ready,
    output logic [ROM_ADDR_WIDTH-1:0]     out_rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0]     in_rom_data,
    output logic                          out_rsp_valid,
    output logic [ID_WIDTH-1:0]           out_rsp_id,
    output logic                          out_rsp_last,
    output logic [ROM_DATA_WIDTH-1:0]     out_rsp_data
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("NUM_REQ must be in 2..8");
        end
        if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_id_width
            $error("ID_WIDTH too narrow for NUM_REQ");
        end
    endgenerate

    // One tag stage alongside the ROM read, then the response register.
    localparam int STAGES = 1;

    seq_state_e state, state_nxt;

    logic [NUM_REQ-1:0][ROM_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]      req_len;

    logic [NUM_REQ-1:0]        gnt;
    logic [ID_WIDTH-1:0]       gnt_idx;
    logic                      gnt_any;
    logic [ROM_ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]      sel_len;

    logic [ID_WIDTH-1:0]       rr_ptr;
    logic [ID_WIDTH-1:0]       burst_id;
    logic [ROM_ADDR_WIDTH-1:0] cur_addr;
    logic [ROM_ADDR_WIDTH-1:0] addr_hold;
    logic [LEN_WIDTH-1:0]      remaining;
    logic [NUM_REQ-1:0]        ready;

    logic                      beat_vld;
    logic                      beat_last;
    logic [ID_WIDTH-1:0]       beat_id;

    logic [STAGES:0]           vld_pipe;
    logic [ID_WIDTH-1:0]       tag_id;
    logic                      tag_last;

    assign req_addr = in_req_addr;
    assign req_len  = in_req_len;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req (in_req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // One-hot mux of the granted requester's fields.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | req_addr[i];
                sel_len  = sel_len  | req_len[i];
            end
        end
    end

    // Next state and beat issue. The IDLE grant cycle already issues beat 0,
    // so back-to-back bursts run without bubbles.
    always_comb begin
        state_nxt    = state;
        ready        = '0;
        out_rom_addr = addr_hold;
        beat_vld     = 1'b0;
        beat_last    = 1'b0;
        beat_id      = burst_id;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    ready        = gnt;
                    out_rom_addr = sel_addr;
                    beat_vld     = 1'b1;
                    beat_id      = gnt_idx;
                    beat_last    = (sel_len == '0);
                    if (sel_len != '0) state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                out_rom_addr = cur_addr;
                beat_vld     = 1'b1;
                beat_last    = (remaining == '0);
                if (remaining == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Gate with reset so no requester sees an accept while held in reset.
    assign out_req_ready = ready & {NUM_REQ{in_rst_n}};

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            burst_id  <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            addr_hold <= '0;
        end else begin
            state     <= state_nxt;
            addr_hold <= out_rom_addr;
            if (state == ST_IDLE && gnt_any) begin
                rr_ptr   <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                burst_id <= gnt_idx;
                if (sel_len != '0) begin
                    cur_addr  <= sel_addr + 1'b1;
                    remaining <= sel_len - 1'b1;
                end
            end else if (state == ST_BURST) begin
                cur_addr <= cur_addr + 1'b1;
                if (remaining != '0) remaining <= remaining - 1'b1;
            end
        end
    end

    // Tag travels with the ROM read; joins the data in the response register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            vld_pipe     <= '0;
            tag_id       <= '0;
            tag_last     <= 1'b0;
            out_rsp_id   <= '0;
            out_rsp_last <= 1'b0;
            out_rsp_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], beat_vld};
            if (beat_vld) begin
                tag_id   <= beat_id;
                tag_last <= beat_last;
            end
            if (vld_pipe[0]) begin
                out_rsp_id   <= tag_id;
                out_rsp_last <= tag_last;
                out_rsp_data <= in_rom_data;
            end
        end
    end

    assign out_rsp_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_rom_lut_sequencer.sv
module tb_rom_lut_sequencer;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LW   = 4;
    localparam int IW   = 3;

    logic                 in_clk = 1'b0;
    logic                 in_rst_n = 1'b0;
    logic [NREQ-1:0]      in_req_valid = '0;
    logic [NREQ*AW-1:0]   in_req_addr = '0;
    logic [NREQ*LW-1:0]   in_req_len = '0;
    logic [NREQ-1:0]      out_req_ready;
    logic [AW-1:0]        out_rom_addr;
    logic [DW-1:0]        rom_q;
    logic                 out_rsp_valid;
    logic [IW-1:0]        out_rsp_id;
    logic                 out_rsp_last;
    logic [DW-1:0]        out_rsp_data;

    rom_lut_sequencer #(
        .NUM_REQ(NREQ), .ROM_ADDR_WIDTH(AW), .ROM_DATA_WIDTH(DW),
        .LEN_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_req_valid(in_req_valid), .in_req_addr(in_req_addr), .in_req_len(in_req_len),
        .out_req_ready(out_req_ready), .out_rom_addr(out_rom_addr), .in_rom_data(rom_q),
        .out_rsp_valid(out_rsp_valid), .out_rsp_id(out_rsp_id),
        .out_rsp_last(out_rsp_last), .out_rsp_data(out_rsp_data)
    );

    always #5 in_clk = ~in_clk;

    // ROM image: mem[a] = a ^ 8'hA5, registered read
    always @(posedge in_clk) rom_q <= out_rom_addr ^ 8'hA5;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [IW-1:0] id;
        logic        last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Requester-side state and the transaction-level reference model
    logic          pend[NREQ];
    logic [AW-1:0] a_addr[NREQ];
    logic [LW-1:0] a_len[NREQ];
    int            m_ptr = 0;
    int            m_left = 0;
    logic [AW-1:0] m_cur = '0;
    int            glog[$];
    int            gcyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            in_req_valid[i]          = pend[i];
            in_req_addr[i*AW +: AW]  = a_addr[i];
            in_req_len[i*LW +: LW]   = a_len[i];
        end
    endtask

    // Whole-burst model: when not busy, pick first pending at/after ptr and
    // queue every beat of that burst with its expected arrival cycle.
    task automatic model_eval();
        logic [NREQ-1:0] exp_rdy;
        logic [AW-1:0]   exp_a;
        logic            act;
        int              g;
        beat_t           b;
        exp_rdy = '0;
        exp_a   = '0;
        act     = 1'b0;
        g       = 0;
        if (m_left == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!act && pend[c]) begin
                    act = 1'b1;
                    g   = c;
                end
            end
            if (act) begin
                exp_rdy[g] = 1'b1;
                exp_a      = a_addr[g];
                for (int k = 0; k <= int'(a_len[g]); k++) begin
                    b.due  = cyc + 2 + k;
                    b.id   = IW'(g);
                    b.last = (k == int'(a_len[g]));
                    b.data = (a_addr[g] + AW'(k)) ^ 8'hA5;
                    sbq.push_back(b);
                end
                m_left = int'(a_len[g]);
                m_cur  = a_addr[g] + 8'd1;
                m_ptr  = (g + 1) % NREQ;
                pend[g] = 1'b0;
                glog.push_back(g);
                gcyc.push_back(cyc);
            end
        end else begin
            act    = 1'b1;
            exp_a  = m_cur;
            m_cur  = m_cur + 8'd1;
            m_left = m_left - 1;
        end
        chk("ready", 64'(out_req_ready), 64'(exp_rdy));
        if (act) chk("rom_addr", 64'(out_rom_addr), 64'(exp_a));
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
        drive();
        @(negedge in_clk);
        model_eval();
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        pend[i]   = 1'b1;
        a_addr[i] = a;
        a_len[i]  = l;
    endtask

    task automatic chk_rst_outs(input string name);
        chk({name, "_ready"}, 64'(out_req_ready), 64'd0);
        chk({name, "_rsp_valid"}, 64'(out_rsp_valid), 64'd0);
        chk({name, "_rsp_id"}, 64'(out_rsp_id), 64'd0);
        chk({name, "_rsp_last"}, 64'(out_rsp_last), 64'd0);
        chk({name, "_rsp_data"}, 64'(out_rsp_data), 64'd0);
    endtask

    // Monitor: every presented beat must match the head of the scoreboard,
    // including its arrival cycle; a beat that is due but absent is missing.
    always @(negedge in_clk) begin
        if (in_rst_n) begin
            if (out_rsp_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_spurious: got id=%0d last=%0b data=%0h, expected no beat (cycle %0d)",
                             out_rsp_id, out_rsp_last, out_rsp_data, cyc);
                end else begin
                    beat_t e;
                    e = sbq.pop_front();
                    if (e.due != cyc || out_rsp_id !== e.id || out_rsp_last !== e.last ||
                        out_rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL rsp_beat: got cyc=%0d id=%0d last=%0b data=%0h, expected cyc=%0d id=%0d last=%0b data=%0h",
                                 cyc, out_rsp_id, out_rsp_last, out_rsp_data, e.due, e.id, e.last, e.data);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                beat_t e;
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing: got no beat, expected id=%0d data=%0h at cycle %0d",
                         e.id, e.data, e.due);
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; a_addr[i] = '0; a_len[i] = '0;
        end
        // Reset state, with a valid request present to show ready is gated
        repeat (3) @(posedge in_clk);
        #1;
        set_req(0, 8'h33, 4'd0);
        drive();
        #1;
        chk_rst_outs("reset");
        pend[0] = 1'b0;
        drive();
        @(negedge in_clk);
        in_rst_n = 1'b1;

        // Single beat
        set_req(0, 8'h10, 4'd0);
        repeat (4) step();

        // Burst with address wrap
        set_req(1, 8'hFE, 4'd3);
        repeat (7) step();

        // Round robin, both continuously valid, len 0
        glog.delete(); gcyc.delete();
        for (int n = 0; n < 8; n++) begin
            if (!pend[0]) set_req(0, AW'($urandom), 4'd0);
            if (!pend[1]) set_req(1, AW'($urandom), 4'd0);
            step();
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int j = 1; j < glog.size(); j++) begin
            chk("rr_alternate", 64'(glog[j] != glog[j-1]), 64'd1);
            chk("rr_no_gap", 64'(gcyc[j] - gcyc[j-1]), 64'd1);
        end
        repeat (3) step();

        // Arrival mid-burst
        glog.delete(); gcyc.delete();
        set_req(0, 8'h40, 4'd7);
        repeat (3) step();
        set_req(1, 8'h80, 4'd2);
        repeat (12) step();
        chk("mid_grants", 64'(glog.size()), 64'd2);
        if (glog.size() >= 2) begin
            chk("mid_first", 64'(glog[0]), 64'd0);
            chk("mid_second", 64'(glog[1]), 64'd1);
            chk("mid_gap", 64'(gcyc[1] - gcyc[0]), 64'd8);
        end

        // Reset mid-burst
        set_req(0, 8'hF8, 4'd15);
        repeat (6) step();
        in_rst_n = 1'b0;
        set_req(0, 8'h20, 4'd1);
        set_req(1, 8'h60, 4'd0);
        drive();
        #1;
        chk_rst_outs("rst_mid");
        sbq.delete();
        m_left = 0; m_ptr = 0;
        glog.delete(); gcyc.delete();
        @(posedge in_clk);
        #1;
        chk_rst_outs("rst_held");
        @(negedge in_clk);
        in_rst_n = 1'b1;
        #1;
        model_eval();
        chk("rst_first_grant", 64'(glog.size() > 0 ? glog[0] : 99), 64'd0);
        repeat (6) step();

        // Randomized traffic, including withdrawn requests
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 3) == 0)
                    set_req(i, AW'($urandom),
                            (($urandom % 4) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 2)));
                else if (pend[i] && m_left > 0 && ($urandom % 16) == 0)
                    pend[i] = 1'b0;
            end
            step();
        end

        // Drain
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 40 && (m_left > 0 || sbq.size() > 0); n++) step();
        repeat (3) step();
        chk("drain_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
